// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART byte-framed add/sub engine.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OPC,
    RX_A,
    RX_B,
    EXEC,
    TX,
    TX_ERR
  } state_t;

  localparam logic [7:0] OPC_ADD  = 8'h01;
  localparam logic [7:0] OPC_SUB  = 8'h02;
  localparam logic [7:0] ERR_BYTE = 8'hEE;

  localparam int STAT_COUT = 0;
  localparam int STAT_OVF  = 1;

endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor; subtraction is A + ~B + 1 so one adder covers both.
module alu_addsub #(
  parameter int OP_WIDTH = 32
) (
  input  logic [OP_WIDTH-1:0] a,
  input  logic [OP_WIDTH-1:0] b,
  input  logic                sub,
  output logic [OP_WIDTH-1:0] r,
  output logic                cout,
  output logic                ovf
);

  logic [OP_WIDTH-1:0] b_eff;
  logic [OP_WIDTH:0]   sum;

  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_eff} + {{OP_WIDTH{1'b0}}, sub};
    r     = sum[OP_WIDTH-1:0];
    cout  = sum[OP_WIDTH];
    // Overflow is judged on the operands the adder actually sees.
    ovf   = (a[OP_WIDTH-1] == b_eff[OP_WIDTH-1]) && (r[OP_WIDTH-1] != a[OP_WIDTH-1]);
  end

endmodule

// File: rtl/uart_alu_frame.sv
// Frame engine: receives opcode + two MSB-first operands, runs the ALU, returns
// the result bytes plus a status byte, with an inter-byte timeout on reception.
module uart_alu_frame
  import uart_alu_pkg::*;
#(
  parameter int OP_WIDTH       = 32,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       rx_overrun,
  output logic       Cout
);

  localparam int NB = OP_WIDTH / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] LAST_RX = CW'(NB - 1);
  localparam logic [CW-1:0] LAST_TX = CW'(NB);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [TW-1:0]       idle_cnt;
  logic [7:0]          opcode;
  logic [OP_WIDTH-1:0] a_reg;
  logic [OP_WIDTH-1:0] b_reg;
  logic [OP_WIDTH-1:0] r_reg;
  logic                ovf_reg;

  logic [OP_WIDTH-1:0] alu_r;
  logic                alu_cout;
  logic                alu_ovf;
  logic                in_rx;
  logic                timeout;
  logic [OP_WIDTH-1:0] r_shifted;
  logic [7:0]          status;

  alu_addsub #(.OP_WIDTH(OP_WIDTH)) u_alu (
    .a    (a_reg),
    .b    (b_reg),
    .sub  (opcode == OPC_SUB),
    .r    (alu_r),
    .cout (alu_cout),
    .ovf  (alu_ovf)
  );

  assign in_rx    = (state == RX_A) || (state == RX_B);
  // A byte landing in the expiry cycle takes priority over the abort.
  assign timeout  = in_rx && !rx_valid && (idle_cnt == TO_LAST);
  assign busy     = (state != IDLE);
  assign tx_valid = (state == TX) || (state == TX_ERR);

  always_comb begin
    r_shifted         = r_reg << {cnt, 3'b000};
    status            = 8'h00;
    status[STAT_COUT] = Cout;
    status[STAT_OVF]  = ovf_reg;
    case (state)
      TX:      tx_byte = (cnt == LAST_TX) ? status : r_shifted[OP_WIDTH-1 -: 8];
      TX_ERR:  tx_byte = ERR_BYTE;
      default: tx_byte = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idle_cnt   <= '0;
      opcode     <= 8'h00;
      a_reg      <= '0;
      b_reg      <= '0;
      r_reg      <= '0;
      ovf_reg    <= 1'b0;
      Cout       <= 1'b0;
      frame_err  <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (rx_valid && (state inside {OPC, EXEC, TX, TX_ERR}))
        rx_overrun <= 1'b1;

      if (in_rx && !rx_valid)
        idle_cnt <= idle_cnt + 1'b1;
      else
        idle_cnt <= '0;

      case (state)
        IDLE: begin
          if (rx_valid) begin
            opcode <= rx_byte;
            state  <= OPC;
            cnt    <= '0;
          end
        end

        OPC: begin
          cnt <= '0;
          if (opcode == OPC_ADD || opcode == OPC_SUB) begin
            state <= RX_A;
          end else begin
            state     <= TX_ERR;
            frame_err <= 1'b1;
          end
        end

        RX_A, RX_B: begin
          if (rx_valid) begin
            if (state == RX_A)
              a_reg <= (a_reg << 8) | OP_WIDTH'(rx_byte);
            else
              b_reg <= (b_reg << 8) | OP_WIDTH'(rx_byte);
            if (cnt == LAST_RX) begin
              state <= (state == RX_A) ? RX_B : EXEC;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (timeout) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b1;
            a_reg     <= '0;
            b_reg     <= '0;
          end
        end

        EXEC: begin
          r_reg   <= alu_r;
          ovf_reg <= alu_ovf;
          Cout    <= alu_cout;
          state   <= TX;
          cnt     <= '0;
        end

        TX: begin
          if (tx_ready) begin
            if (cnt == LAST_TX) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        TX_ERR: begin
          if (tx_ready) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_frame.sv
// Scoreboard bench for uart_alu_frame: frames are issued with random spacing and
// backpressure, expected bytes come from an arithmetic reference model.
module tb_uart_alu_frame;

  localparam int W  = 32;
  localparam int NB = W / 8;
  localparam int TO = 1000;
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic       sys_clk;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       frame_err;
  logic       rx_overrun;
  logic       Cout;

  int         n_vec   = 0;
  int         n_err   = 0;
  int         fe_seen = 0;
  logic [7:0] exp_q[$];
  logic       exp_cout  = 1'b0;
  logic       bp_mode   = 1'b0;
  logic       rdy_fixed = 1'b1;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_byte = 8'h00;

  uart_alu_frame #(.OP_WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .rx_overrun (rx_overrun),
    .Cout       (Cout)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the whole operands.
  function automatic void model(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v);
    longint sa, sb, sr;
    logic [32:0] full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (opc == 8'h01) begin
      full = {1'b0, a} + {1'b0, b};
      r    = full[31:0];
      c    = full[32];
      sr   = sa + sb;
    end else begin
      r  = a - b;
      c  = (a >= b);
      sr = sa - sb;
    end
    v = (sr > SMAX) || (sr < SMIN);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic push_expect(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic c, v;
    if (opc == 8'h01 || opc == 8'h02) begin
      model(opc, a, b, r, c, v);
      for (int i = 0; i < NB; i++) exp_q.push_back(r[W-1-8*i -: 8]);
      exp_q.push_back({6'b0, v, c});
      exp_cout = c;
    end else begin
      exp_q.push_back(8'hEE);
    end
  endtask

  task automatic issue_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                             input int maxgap);
    push_expect(opc, a, b);
    send_byte(opc);
    if (opc == 8'h01 || opc == 8'h02) begin
      idle(1);
      for (int i = 0; i < NB; i++) begin
        send_byte(a[W-1-8*i -: 8]);
        idle(int'($urandom_range(0, maxgap)));
      end
      for (int i = 0; i < NB; i++) begin
        send_byte(b[W-1-8*i -: 8]);
        if (i < NB - 1) idle(int'($urandom_range(0, maxgap)));
      end
    end
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 3000) begin
      idle(1);
      k++;
    end
    if (k >= 3000) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d bytes outstanding, busy=%b", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic do_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input int maxgap);
    int fe0;
    bit bad;
    fe0 = fe_seen;
    bad = !(opc == 8'h01 || opc == 8'h02);
    issue_frame(opc, a, b, maxgap);
    wait_drain();
    check("cout_flag", Cout, exp_cout);
    check("frame_err_count", fe_seen, fe0 + (bad ? 1 : 0));
  endtask

  task automatic check_zero();
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_byte", tx_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_rx_overrun", rx_overrun, 0);
    check("rst_cout", Cout, 0);
  endtask

  always @(posedge sys_clk) begin
    #1;
    tx_ready = bp_mode ? logic'($urandom_range(0, 1)) : rdy_fixed;
  end

  // Monitor: pops the scoreboard on every handshake, checks stall stability.
  always @(negedge sys_clk) begin
    if (!rst) begin
      stall_pend = 1'b0;
    end else begin
      if (frame_err) fe_seen++;
      if (stall_pend && tx_valid) check("tx_stable", tx_byte, stall_byte);
      if (tx_valid && tx_ready) begin
        stall_pend = 1'b0;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL tx_unexpected: got %h, expected no byte", tx_byte);
        end else begin
          check("tx_byte", tx_byte, exp_q.pop_front());
        end
      end else if (tx_valid) begin
        stall_pend = 1'b1;
        stall_byte = tx_byte;
      end else begin
        stall_pend = 1'b0;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] corner [5];
    logic [31:0] a, b;
    logic [7:0]  opc;
    int          fe0, k;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'h7FFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'hFFFF_FFFF;

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    tx_ready = 1'b1;
    idle(3);
    check_zero();
    rst = 1'b1;
    idle(2);

    // Subtraction with and without borrow, then signed overflow cases.
    do_frame(8'h02, 32'h0000_0001, 32'h0000_0002, 1);
    do_frame(8'h02, 32'h0000_0002, 32'h0000_0001, 1);
    do_frame(8'h01, 32'h7FFF_FFFF, 32'h0000_0001, 1);
    do_frame(8'h01, 32'hFFFF_FFFF, 32'h0000_0001, 1);

    // Bad opcode, then a normal frame.
    do_frame(8'h7F, 32'h0, 32'h0, 0);
    do_frame(8'h01, 32'h1234_5678, 32'h1111_1111, 2);

    // Byte during TX with the transmitter stalled.
    check("overrun_clear", rx_overrun, 0);
    rdy_fixed = 1'b0;
    idle(2);
    issue_frame(8'h02, 32'h0000_0005, 32'h0000_0003, 1);
    idle(2);
    check("stalled_tx_valid", tx_valid, 1);
    send_byte(8'h55);
    check("overrun_set", rx_overrun, 1);
    rdy_fixed = 1'b1;
    wait_drain();
    check("cout_after_overrun", Cout, exp_cout);
    do_frame(8'h01, 32'h0000_0010, 32'h0000_0020, 1);
    check("overrun_sticky", rx_overrun, 1);

    // Reset in the middle of operand A.
    send_byte(8'h01);
    idle(1);
    send_byte(8'h12);
    send_byte(8'h34);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      check_zero();
    end
    rst      = 1'b1;
    exp_cout = 1'b0;
    idle(1);
    do_frame(8'h01, 32'h0000_0002, 32'h0000_0001, 1);
    check("overrun_after_reset", rx_overrun, 0);

    // Timeout: 1000 silent cycles mid-operand abort the frame.
    fe0 = fe_seen;
    send_byte(8'h01);
    idle(1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    idle(TO);
    check("timeout_pulse", frame_err, 1);
    check("timeout_busy", busy, 0);
    idle(2);
    check("timeout_err_count", fe_seen, fe0 + 1);

    // A byte exactly at expiry is accepted and the frame completes.
    fe0 = fe_seen;
    push_expect(8'h01, 32'hAA11_2233, 32'h0000_0010);
    send_byte(8'h01);
    idle(1);
    send_byte(8'hAA);
    idle(TO - 1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    for (int i = 0; i < NB; i++) send_byte((i == NB - 1) ? 8'h10 : 8'h00);
    wait_drain();
    check("expiry_accept_err", fe_seen, fe0);
    check("expiry_accept_cout", Cout, exp_cout);

    // Randomized frames under random backpressure.
    bp_mode = 1'b1;
    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, 9));
      if (k < 4)      opc = 8'h01;
      else if (k < 8) opc = 8'h02;
      else            opc = 8'($urandom_range(3, 255));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      do_frame(opc, a, b, 2);
    end
    bp_mode = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_alu_frame.md
# uart_alu_frame

Byte-level protocol engine between the UART receiver/transmitter byte interfaces and the arithmetic datapath. It generalises the fixed 32-bit add/sub UART path in three ways: operand width is a parameter, the operation is selected per frame by an opcode byte, and every result is followed by a status byte. It also enforces an inter-byte timeout so that a truncated frame cannot hang the block. The block sits between the UART RX/TX byte handlers and the board I/O, in the `sys_clk` domain.

## Interface
- `OP_WIDTH`, 32: operand and result width in bits. Must be a multiple of 8, in the range 8–128. NB = OP_WIDTH/8.
- `TIMEOUT_CYCLES`, 1_000_000: number of `sys_clk` cycles allowed between received bytes within a frame.
- `sys_clk` in 1: the single clock. Everything is synchronous to its rising edge.
- `rst` in 1: reset, synchronous and active-low. Sampled on the rising edge of `sys_clk`.
- `rx_byte` in 8: received byte from the UART RX.
- `rx_valid` in 1: one-cycle strobe; `rx_byte` is valid in that cycle.
- `tx_byte` out 8: byte for the UART TX.
- `tx_valid` out 1: `tx_byte` is valid.
- `tx_ready` in 1: the TX accepts the byte in any cycle where `tx_valid && tx_ready`.
- `busy` out 1: high in every state except IDLE.
- `frame_err` out 1: one-cycle pulse on a timeout abort or a bad opcode.
- `rx_overrun` out 1: sticky flag, set when a byte arrives during EXEC or TX; cleared only by reset.
- `Cout` out 1: carry out of the last completed operation, registered.

## Operation
- **Frame format (request):** opcode byte, then operand A as NB bytes MSB-first, then operand B as NB bytes MSB-first.
- **Opcodes:**
  - 0x01 ADD: R = A + B.
  - 0x02 SUB: R = A + ~B + 1.
  - Any other value: error response.
- **Flags:**
  - `cout` is the carry out of bit OP_WIDTH-1. For SUB, `cout` = 1 means no borrow.
  - `ovf` is signed overflow: operand signs as seen by the adder (A and B for ADD, A and ~B for SUB) are equal, and the result sign differs from them.
- **Response (normal):** R as NB bytes MSB-first, then the status byte {6'b0, ovf, cout}. The response is always NB+1 bytes.
- **Response (bad opcode):** the single byte 0xEE, plus a `frame_err` pulse.
- **States:**
  - IDLE: a byte arrives → OPC.
  - OPC (one cycle): decode the opcode. Valid → RX_A. Invalid → TX_ERR.
  - RX_A: shift in NB bytes, then → RX_B.
  - RX_B: shift in NB bytes, then → EXEC.
  - EXEC (one cycle): register R, `cout`, `ovf`, and update `Cout` → TX.
  - TX: send NB+1 bytes, then → IDLE.
  - TX_ERR: send 0xEE, then → IDLE.
- **Byte counter:** log2(NB+1) bits. Cleared on every state change.
- **Timeout:** in RX_A and RX_B, a cycle counter resets on each accepted byte. When it reaches TIMEOUT_CYCLES-1 with no byte:
  - → IDLE, pulse `frame_err`, discard the partial operands.
  - A byte that arrives in the same cycle as expiry wins: it is accepted and the counter restarts.
- **Dropped bytes:** bytes arriving in EXEC, TX or TX_ERR are dropped and set `rx_overrun`. A byte arriving in OPC is also dropped and flagged.
- **Reset (also mid-frame or mid-TX):** state → IDLE. Outputs take these values:
  - `tx_valid`=0, `tx_byte`=0x00, `busy`=0.
  - `frame_err`=0, `rx_overrun`=0, `Cout`=0.
  - Operand registers are cleared.

## Timing
- Opcode accepted at cycle T → OPC at T+1 → RX_A at T+2.
- Last B byte accepted at cycle N → EXEC at N+1 → `tx_valid`=1 with the first R byte at N+2.
- TX handshake:
  - `tx_byte` is stable while `tx_valid`=1 and `tx_ready`=0.
  - After a handshake, the next byte is presented in the following cycle, so back-to-back bytes are allowed.
- After the handshake on the last byte, `tx_valid` drops in the next cycle and the state returns to IDLE. A new opcode is accepted from that cycle onward.
- `frame_err` is asserted in the cycle after the timeout condition or the OPC decode.
- Throughput when `tx_ready` is tied high: a response completes in NB+1 cycles after EXEC.

## Structure
- **Package `uart_alu_pkg`:**
  - `state_t` enum: IDLE, OPC, RX_A, RX_B, EXEC, TX, TX_ERR.
  - Opcode constants OPC_ADD = 8'h01 and OPC_SUB = 8'h02.
  - ERR_BYTE = 8'hEE.
  - Status bit indices: STAT_COUT = 0, STAT_OVF = 1.
- **Sub-module `alu_addsub #(OP_WIDTH)`:** combinational. Inputs `a`, `b`, `sub`. Outputs `r`, `cout`, `ovf`. Registered in EXEC by the parent.
- The FSM, shift registers, timeout counter and TX mux stay in `uart_alu_frame`.

## Test plan
All cases use OP_WIDTH=32 and TIMEOUT_CYCLES=1000, with `tx_ready` held high unless stated otherwise.

- **Reset:** hold `rst`=0 for 3 cycles mid-RX_A, then release and send a full frame 01 00000002 00000001 → response 00 00 00 03 00. Check every output is 0 during reset.
- **SUB with borrow:** 02 00000001 00000002 → FF FF FF FF 00 (`cout`=0, `ovf`=0), `Cout`=0. Then 02 00000002 00000001 → 00 00 00 01 01, `Cout`=1.
- **Signed overflow:** 01 7FFFFFFF 00000001 → 80 00 00 00 02. 01 FFFFFFFF 00000001 → 00 00 00 00 01.
- **Bad opcode:** 7F → a single 0xEE byte and a one-cycle `frame_err` pulse. The next valid ADD frame responds correctly.
- **Timeout:** send 01 AA BB, then stay idle for 1000 cycles → `frame_err` pulse and `busy`=0. A byte arriving exactly at expiry is accepted instead of aborting the frame.
- **Backpressure and overrun:** toggle `tx_ready` randomly during TX → `tx_byte` stays stable while stalled and the byte order is preserved. An `rx_valid` during TX sets `rx_overrun`, which stays set until reset.
